// File: rtl/mem_dump_unit_pkg.sv
// rtl/mem_dump_unit_pkg.sv - shared types and constants for the data-memory dump unit
// Contents: state enumeration, header sync byte, bytes-per-word helper.
// Optional build macro: MEM_DUMP_HEADER_EN adds the header states.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
`ifdef MEM_DUMP_HEADER_EN
        HDR_SEND = 3'd1,
        HDR_WAIT = 3'd2,
`endif
        READ     = 3'd3,
        CAPTURE  = 3'd4,
        SEND     = 3'd5,
        WAIT     = 3'd6,
        FINISH   = 3'd7
    } state_t;

    localparam logic [7:0] HDR_SYNC = 8'hA5;

    function automatic int bytes_per_word(input int db);
        return db / 8;
    endfunction

endpackage

// File: rtl/mem_dump_unit_if.sv
// rtl/mem_dump_unit_if.sv - memory-read and UART-byte handshake bundle for mem_dump_unit
// Signals: start request, RdRam/Addr/Mem_Data memory read port,
//          tx_start/tx_data/tx_done UART byte handshake, busy/done status.
// Modports: master = dump unit side, slave = memory/UART/host side.
interface mem_dump_unit_if #(
    parameter int AB = 11,
    parameter int DB = 16
);
    logic          start;
    logic          RdRam;
    logic [AB-1:0] Addr;
    logic [DB-1:0] Mem_Data;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;
    logic          done;

    modport master (
        input  start, Mem_Data, tx_done,
        output RdRam, Addr, tx_start, tx_data, busy, done
    );

    modport slave (
        output start, Mem_Data, tx_done,
        input  RdRam, Addr, tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/mem_dump_unit.sv
// rtl/mem_dump_unit.sv - walks data memory 0..N_WORDS-1 and streams each word MSB byte first to a UART
// Ports: clk, reset (async, active high), bus (mem_dump_unit_if.master).
// Optional build macro: MEM_DUMP_HEADER_EN sends sync byte and word count before the data.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int AB      = 11,
    parameter int DB      = 16,
    parameter int N_WORDS = 9
) (
    input  logic            clk,
    input  logic            reset,
    mem_dump_unit_if.master bus
);

    localparam int             BYTES     = bytes_per_word(DB);
    // At least one bit: the header path also counts two bytes with this register.
    localparam int             BW        = (BYTES > 2) ? $clog2(BYTES) : 1;
    localparam logic [AB-1:0]  LAST_IDX  = AB'(N_WORDS - 1);
    localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES - 1);
`ifdef MEM_DUMP_HEADER_EN
    localparam logic [7:0]     HDR_COUNT = 8'(N_WORDS);
`endif

    state_t        state, state_nx;
    logic [AB-1:0] index;
    logic [BW-1:0] byte_cnt;
    logic [DB-1:0] shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef MEM_DUMP_HEADER_EN
                    state_nx = HDR_SEND;
`else
                    state_nx = READ;
`endif
                end
            end
`ifdef MEM_DUMP_HEADER_EN
            HDR_SEND: state_nx = HDR_WAIT;
            HDR_WAIT: begin
                if (bus.tx_done) begin
                    state_nx = (byte_cnt != '0) ? HDR_SEND : READ;
                end
            end
`endif
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = SEND;
            SEND:    state_nx = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (byte_cnt != '0) begin
                        state_nx = SEND;
                    end else if (index == LAST_IDX) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index    <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        index <= '0;
`ifdef MEM_DUMP_HEADER_EN
                        // Non-zero selects the sync byte, zero selects the count byte.
                        byte_cnt <= BW'(1);
`endif
                    end
                end
`ifdef MEM_DUMP_HEADER_EN
                HDR_WAIT: begin
                    if (bus.tx_done && byte_cnt != '0) begin
                        byte_cnt <= byte_cnt - BW'(1);
                    end
                end
`endif
                CAPTURE: begin
                    shift    <= bus.Mem_Data;
                    byte_cnt <= LAST_BYTE;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        shift <= shift << 8;
                        if (byte_cnt != '0) begin
                            byte_cnt <= byte_cnt - BW'(1);
                        end else if (index != LAST_IDX) begin
                            index <= index + AB'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the registered state, so they drop together with the async reset.
    // Addr follows index, which only moves on entry to READ, so it holds between reads.
    always_comb begin
        bus.RdRam    = (state == READ);
        bus.Addr     = index;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        bus.busy     = (state != IDLE);
        bus.done     = (state == FINISH);
        case (state)
            SEND: begin
                bus.tx_start = 1'b1;
                bus.tx_data  = shift[DB-1 -: 8];
            end
`ifdef MEM_DUMP_HEADER_EN
            HDR_SEND: begin
                bus.tx_start = 1'b1;
                bus.tx_data  = (byte_cnt != '0) ? HDR_SYNC : HDR_COUNT;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dump_unit.sv
// tb/tb_mem_dump_unit.sv - self-checking bench for mem_dump_unit
module tb_mem_dump_unit;

    localparam int AB    = 11;
    localparam int DB    = 16;
    localparam int NW    = 9;
    localparam int BYTES = DB / 8;
`ifdef MEM_DUMP_HEADER_EN
    localparam int HDR_N = 2;
`else
    localparam int HDR_N = 0;
`endif

    logic clk;
    logic reset;

    mem_dump_unit_if #(.AB(AB), .DB(DB)) m ();
    mem_dump_unit_if #(.AB(AB), .DB(DB)) m1 ();

    mem_dump_unit #(.AB(AB), .DB(DB), .N_WORDS(NW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    mem_dump_unit #(.AB(AB), .DB(DB), .N_WORDS(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (m1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [DB-1:0] mem [0:2047];
    logic [7:0]    rx[$];
    logic [7:0]    exp_q[$];
    bit            spur_en = 1'b0;
    int            uart_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Memory and UART model for the main instance, acting on the falling edge.
    initial begin
        m.tx_done  = 1'b0;
        m.Mem_Data = '0;
        forever begin
            @(negedge clk);
            if (m.RdRam) m.Mem_Data = mem[m.Addr];
            m.tx_done = 1'b0;
            if (m.tx_start) begin
                rx.push_back(m.tx_data);
                uart_cnt = 5;
                if (spur_en) m.tx_done = 1'b1;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) m.tx_done = 1'b1;
            end else if (spur_en) begin
                m.tx_done = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Expected byte stream straight from the dump rules.
    task automatic build_expected();
        exp_q.delete();
`ifdef MEM_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NW));
`endif
        for (int w = 0; w < NW; w++) begin
            for (int b = BYTES - 1; b >= 0; b--) begin
                exp_q.push_back(mem[w][8*b +: 8]);
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        chk({tag, "_count"}, rx.size(), exp_q.size());
        n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
        end
    endtask

    task automatic do_dump(input string tag, input bit spur, input bit timing_chk);
        int  rd_seen;
        bit  prev_rd;
        bit  got_done;
        int  extra;
        rx.delete();
        build_expected();
        spur_en  = spur;
        rd_seen  = 0;
        prev_rd  = 1'b0;
        got_done = 1'b0;
        @(negedge clk);
        m.start = 1'b1;
        @(negedge clk);
        m.start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (timing_chk) begin
`ifdef MEM_DUMP_HEADER_EN
                if (cyc == 0) begin
                    chk("t_hdr_txstart", m.tx_start, 1);
                    chk("t_hdr_sync", m.tx_data, 8'hA5);
                    chk("t_hdr_rdram", m.RdRam, 0);
                end
`else
                if (cyc == 0) begin
                    chk("t_rdram_k1", m.RdRam, 1);
                    chk("t_addr_k1", m.Addr, 0);
                    chk("t_txstart_k1", m.tx_start, 0);
                end
                if (cyc == 1) begin
                    chk("t_rdram_k2", m.RdRam, 0);
                    chk("t_txstart_k2", m.tx_start, 0);
                end
                if (cyc == 2) begin
                    chk("t_txstart_k3", m.tx_start, 1);
                    chk("t_txdata_k3", m.tx_data, exp_q[0]);
                end
`endif
            end
            chk({tag, "_busy"}, m.busy, 1);
            if (m.RdRam) begin
                chk({tag, "_rd_single"}, prev_rd, 0);
                chk({tag, "_rd_addr"}, m.Addr, rd_seen);
                rd_seen++;
            end
            prev_rd = m.RdRam;
            if (m.done) begin
                got_done = 1'b1;
                m.start  = 1'b0;
                break;
            end
            m.start = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        m.start = 1'b0;
        chk({tag, "_done_seen"}, got_done, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, m.busy, 0);
        chk({tag, "_done_after"}, m.done, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m.busy || m.done) extra++;
        end
        chk({tag, "_quiet"}, extra, 0);
        chk({tag, "_reads"}, rd_seen, NW);
        spur_en = 1'b0;
        compare_stream(tag);
    endtask

    initial begin
        int  cnt1;
        bit  got1;
        logic [7:0] q1[$];
        logic [7:0] e1[$];
        bit  reached;

        reset       = 1'b1;
        m.start     = 1'b0;
        m1.start    = 1'b0;
        m1.tx_done  = 1'b0;
        m1.Mem_Data = 16'hBEEF;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        repeat (3) @(negedge clk);

        chk("rst_rdram", m.RdRam, 0);
        chk("rst_addr", m.Addr, 0);
        chk("rst_txstart", m.tx_start, 0);
        chk("rst_txdata", m.tx_data, 0);
        chk("rst_busy", m.busy, 0);
        chk("rst_done", m.done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed pattern with timing checks.
        mem[4] = 16'h3FC0;
        do_dump("pat", 1'b0, 1'b1);
        chk("pat_total", rx.size(), HDR_N + 18);
        if (rx.size() >= HDR_N + 10) begin
            chk("pat_b8", rx[HDR_N + 8], 8'h3F);
            chk("pat_b9", rx[HDR_N + 9], 8'hC0);
        end

        // Random contents, stray start and tx_done pulses.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) mem[i] = DB'($urandom);
            do_dump($sformatf("rnd%0d", r), 1'b1, 1'b0);
        end

        // Reset while waiting on word 3, byte 1.
        for (int i = 0; i < NW; i++) mem[i] = DB'($urandom);
        rx.delete();
        @(negedge clk);
        m.start = 1'b1;
        @(negedge clk);
        m.start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (rx.size() == HDR_N + 8) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reached", reached, 1);
        @(negedge clk);
        chk("abort_pre_busy", m.busy, 1);
        chk("abort_pre_addr", m.Addr, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_rdram", m.RdRam, 0);
        chk("abort_addr", m.Addr, 0);
        chk("abort_txstart", m.tx_start, 0);
        chk("abort_txdata", m.tx_data, 0);
        chk("abort_busy", m.busy, 0);
        chk("abort_done", m.done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        do_dump("restart", 1'b0, 1'b0);

        // Single-word instance.
        e1.delete();
`ifdef MEM_DUMP_HEADER_EN
        e1.push_back(8'hA5);
        e1.push_back(8'h01);
`endif
        e1.push_back(8'hBE);
        e1.push_back(8'hEF);
        q1.delete();
        cnt1 = 0;
        got1 = 1'b0;
        @(negedge clk);
        m1.start = 1'b1;
        @(negedge clk);
        m1.start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            m1.tx_done = 1'b0;
            if (m1.RdRam) chk("one_addr", m1.Addr, 0);
            if (m1.tx_start) begin
                q1.push_back(m1.tx_data);
                cnt1 = 3;
            end else if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) m1.tx_done = 1'b1;
            end
            if (m1.done) begin
                got1 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        m1.tx_done = 1'b0;
        chk("one_done", got1, 1);
        chk("one_count", q1.size(), e1.size());
        for (int i = 0; i < e1.size() && i < q1.size(); i++) begin
            chk($sformatf("one_byte%0d", i), q1[i], e1[i]);
        end
        @(negedge clk);
        chk("one_busy_after", m1.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
